// File: rtl/wbslave_timer_pkg.sv
// Shared constants for the Wishbone timer slave: register map, CTRL bit
// positions and bus handshake states.
package wbslave_timer_pkg;

   localparam logic [2:0] WBT_CTRL  = 3'd0;
   localparam logic [2:0] WBT_STAT  = 3'd1;
   localparam logic [2:0] WBT_LOAD  = 3'd2;
   localparam logic [2:0] WBT_COUNT = 3'd3;
   localparam logic [2:0] WBT_SCR0  = 3'd4;
   localparam logic [2:0] WBT_SCR3  = 3'd7;

   localparam int unsigned CTRL_EN   = 0;
   localparam int unsigned CTRL_IE   = 1;
   localparam int unsigned CTRL_AUTO = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } bus_state_t;

endpackage

// File: rtl/wbslave_timer_cnt.sv
// Timer core: CTRL, LOAD, COUNT and the sticky IRQ flag, updated from
// single-cycle write strobes issued by the bus FSM.
module wbslave_timer_cnt
   import wbslave_timer_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ctrl_we,
   input  logic          stat_we,
   input  logic          load_we,
   input  logic [DW-1:0] wdata,
   output logic [2:0]    ctrl,
   output logic [DW-1:0] load,
   output logic [DW-1:0] count,
   output logic          irq
);

   logic tick_zero;
   logic arm;

   // Expiry detect and the "enable while already at zero" reload case
   always_comb begin
      tick_zero = ctrl[CTRL_EN] && (count == '0);
      arm       = ctrl_we && wdata[CTRL_EN] && !ctrl[CTRL_EN] && (count == '0);
   end

   // Control register; a software write wins over the one-shot self-clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl <= '0;
      end else if (ctrl_we) begin
         ctrl <= wdata[2:0];
      end else if (tick_zero && !ctrl[CTRL_AUTO]) begin
         ctrl[CTRL_EN] <= 1'b0;
      end
   end

   // Reload value and down-counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load  <= '0;
         count <= '0;
      end else begin
         if (load_we) begin
            load  <= wdata;
            count <= wdata;
         end else if (arm) begin
            count <= load;
         end else if (tick_zero) begin
            if (ctrl[CTRL_AUTO]) begin
               count <= load;
            end
         end else if (ctrl[CTRL_EN]) begin
            count <= count - 1'b1;
         end
      end
   end

   // Sticky IRQ; a set on expiry beats a simultaneous write-one-to-clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq <= 1'b0;
      end else if (tick_zero) begin
         irq <= 1'b1;
      end else if (stat_we && wdata[0]) begin
         irq <= 1'b0;
      end
   end

endmodule

// File: rtl/wbslave_timer.sv
// Wishbone classic slave: address decode, handshake FSM with optional wait
// states, scratch registers, read mux, and the timer core.
module wbslave_timer
   import wbslave_timer_pkg::*;
#(
   parameter int AW          = 8,
   parameter int DW          = 8,
   parameter int SW          = 1,
   parameter int WAIT_STATES = 0
) (
   input  logic          CLK_I,
   input  logic          RST_I,
   input  logic [AW-1:0] ADR_I,
   input  logic [DW-1:0] DAT_I,
   output logic [DW-1:0] DAT_O,
   input  logic          WE_I,
   input  logic [SW-1:0] SEL_I,
   input  logic          STB_I,
   input  logic          CYC_I,
   output logic          ACK_O,
   output logic          ERR_O,
   output logic          INTR_O
);

   localparam logic [2:0] WS_LAST = 3'(WAIT_STATES - 1);

   bus_state_t    state, nstate;
   logic [2:0]    wcnt, wcnt_n;
   logic          req, mapped, resp, wr;
   logic [2:0]    off;
   logic [DW-1:0] rdata;
   logic [DW-1:0] scr [4];
   logic [2:0]    ctrl;
   logic [DW-1:0] load, count;
   logic          irq;

   // Request qualification and decode; responses need the request still present
   always_comb begin
      req    = STB_I && CYC_I;
      mapped = (ADR_I[AW-1:3] == '0);
      off    = ADR_I[2:0];
      resp   = (state == ST_RESP) && req;
      wr     = resp && mapped && WE_I && SEL_I[0];
   end

   // Handshake next-state logic; a dropped request in WAIT aborts silently
   always_comb begin
      nstate = state;
      wcnt_n = wcnt;
      case (state)
         ST_IDLE: begin
            if (req) begin
               wcnt_n = '0;
               nstate = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!req) begin
               nstate = ST_IDLE;
            end else if (wcnt == WS_LAST) begin
               nstate = ST_RESP;
            end else begin
               wcnt_n = wcnt + 3'd1;
            end
         end
         ST_RESP: nstate = ST_IDLE;
         default: nstate = ST_IDLE;
      endcase
   end

   // Handshake state and wait counter
   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         state <= ST_IDLE;
         wcnt  <= '0;
      end else begin
         state <= nstate;
         wcnt  <= wcnt_n;
      end
   end

   // Scratch registers at offsets 4..7
   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         for (int unsigned i = 0; i < 4; i++) scr[i] <= '0;
      end else if (wr && off[2]) begin
         scr[off[1:0]] <= DAT_I;
      end
   end

   wbslave_timer_cnt #(.DW(DW)) u_cnt (
      .clk     (CLK_I),
      .rst_n   (RST_I),
      .ctrl_we (wr && (off == WBT_CTRL)),
      .stat_we (wr && (off == WBT_STAT)),
      .load_we (wr && (off == WBT_LOAD)),
      .wdata   (DAT_I),
      .ctrl    (ctrl),
      .load    (load),
      .count   (count),
      .irq     (irq)
   );

   // Read mux and bus outputs; data is driven only alongside ACK
   always_comb begin
      rdata = '0;
      case (off)
         WBT_CTRL:  rdata[2:0] = ctrl;
         WBT_STAT:  rdata[0]   = irq;
         WBT_LOAD:  rdata      = load;
         WBT_COUNT: rdata      = count;
         default:   rdata      = scr[off[1:0]];
      endcase
      ACK_O  = resp && mapped;
      ERR_O  = resp && !mapped;
      DAT_O  = ACK_O ? rdata : '0;
      INTR_O = irq && ctrl[CTRL_IE];
   end

endmodule
